// File: rtl/blue_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : blue_pkg
//  Purpose  : Shared opcodes, instruction field positions and sequencer states.
//  Revision : 1.0
// ============================================================================
package blue_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_EXCH = 3'b111;

  localparam int HALT_BIT = 12;
  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    FIN   = 2'd3
  } state_e;

  function automatic logic is_halt(input logic [15:0] ins);
    return ins[HALT_BIT];
  endfunction

endpackage
`default_nettype wire

// File: rtl/blue_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : blue_sequencer_if
//  Purpose  : Sequencer <-> blue datapath bus (instruction, operands, results).
//  Revision : 1.0
// ============================================================================
interface blue_sequencer_if #(
  parameter int DW = 16
) ();

  logic [DW-1:0] INS;
  logic [DW-1:0] RA;
  logic [DW-1:0] RB;
  logic [DW-1:0] ALU_RA;
  logic [DW-1:0] ALU_RB;

  modport master (output INS, output RA, output RB, input ALU_RA, input ALU_RB);
  modport slave  (input INS, input RA, input RB, output ALU_RA, output ALU_RB);

endinterface
`default_nettype wire

// File: rtl/blue.sv
`default_nettype none
// ============================================================================
//  Module   : blue
//  Purpose  : Combinational RA/RB datapath driven by the sequencer's IR.
//  Revision : 1.0
// ============================================================================
module blue
  import blue_pkg::*;
(
  input  logic [15:0] ins,
  input  logic [15:0] RA,
  input  logic [15:0] RB,
  output logic [15:0] RA_OUT,
  output logic [15:0] RB_OUT
);

  logic [2:0]  w_op;
  logic        w_unused_ins;

  assign w_op         = ins[OP_MSB:OP_LSB];
  assign w_unused_ins = ^ins[12:0];

  always_comb begin
    RA_OUT = RA;
    RB_OUT = RB;
    case (w_op)
      OP_ADD:  RA_OUT = RA + RB;
      OP_SUB:  RA_OUT = RA - RB;
      OP_OR:   RA_OUT = RA | RB;
      OP_AND:  RA_OUT = RA & RB;
      OP_XOR:  RA_OUT = RA ^ RB;
      OP_SHR:  RA_OUT = RA >> 1;
      OP_MOV:  RB_OUT = RA;
      OP_EXCH: begin
        RA_OUT = RB;
        RB_OUT = RA;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/blue_imem.sv
`default_nettype none
// ============================================================================
//  Module   : blue_imem
//  Purpose  : Program memory, synchronous write, registered read feeding the IR.
//  Revision : 1.0
// ============================================================================
module blue_imem #(
  parameter int AW = 4,
  parameter int DW = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q, rdata_d;

  // Array contents survive reset; only the read register is cleared.
  always_ff @(posedge CLK) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (i_re) rdata_d = mem[i_raddr];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign o_rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/blue_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : blue_sequencer
//  Purpose  : Fetches instructions for blue and writes its results back to RA/RB.
//  Revision : 1.0
// ============================================================================
module blue_sequencer
  import blue_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [DW-1:0]    RA_INIT,
  input  logic [DW-1:0]    RB_INIT,
  input  logic             PROG_WE,
  input  logic [AW-1:0]    PROG_ADDR,
  input  logic [DW-1:0]    PROG_DATA,
  blue_sequencer_if.master dp,
  output logic [AW-1:0]    PC,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVERRUN
);

  localparam logic [AW-1:0] c_pc_last = '1;

  state_e        state_q, state_d;
  logic [DW-1:0] ra_q, ra_d;
  logic [DW-1:0] rb_q, rb_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          overrun_q, overrun_d;
  logic [DW-1:0] w_ins;
  logic          w_fetch;
  logic          w_prog_we;

  assign BUSY      = (state_q == FETCH) || (state_q == EXEC);
  assign w_fetch   = (state_q == FETCH);
  assign w_prog_we = PROG_WE && !BUSY;

  // The imem read register is the IR: loaded in FETCH, held through EXEC/FIN.
  blue_imem #(.AW(AW), .DW(DW)) u_imem (
    .CLK     (CLK),
    .RST     (RST),
    .i_we    (w_prog_we),
    .i_waddr (PROG_ADDR),
    .i_wdata (PROG_DATA),
    .i_re    (w_fetch),
    .i_raddr (pc_q),
    .o_rdata (w_ins)
  );

  always_comb begin
    state_d   = state_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    pc_d      = pc_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          ra_d      = RA_INIT;
          rb_d      = RB_INIT;
          pc_d      = '0;
          overrun_d = 1'b0;
          state_d   = FETCH;
        end
      end
      FETCH: state_d = EXEC;
      EXEC: begin
        if (is_halt(w_ins)) begin
          state_d = FIN;
        end else begin
          ra_d = dp.ALU_RA;
          rb_d = dp.ALU_RB;
          // The PC never wraps: the last slot ends the run as an overrun.
          if (pc_q == c_pc_last) begin
            overrun_d = 1'b1;
            state_d   = FIN;
          end else begin
            pc_d    = pc_q + AW'(1);
            state_d = FETCH;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      ra_q      <= '0;
      rb_q      <= '0;
      pc_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      pc_q      <= pc_d;
      overrun_q <= overrun_d;
    end
  end

  assign dp.INS  = w_ins;
  assign dp.RA   = ra_q;
  assign dp.RB   = rb_q;
  assign PC      = pc_q;
  assign DONE    = (state_q == FIN);
  assign OVERRUN = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_blue_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_blue_sequencer
//  Purpose  : Closed-loop bench (sequencer + blue) against a program-level model.
//  Revision : 1.0
// ============================================================================
module tb_blue_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] ra_init = '0;
  logic [15:0] rb_init = '0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic [3:0]  pc;
  logic        busy, done, overrun;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] model_mem [16];
  logic [15:0] tr_ra [17];
  logic [15:0] tr_rb [17];
  int          exp_k;
  logic        exp_ovr;

  blue_sequencer_if #(.DW(16)) dp_if ();

  blue_sequencer #(.AW(4), .DW(16)) u_dut (
    .CLK       (clk),
    .RST       (rst),
    .START     (start),
    .RA_INIT   (ra_init),
    .RB_INIT   (rb_init),
    .PROG_WE   (prog_we),
    .PROG_ADDR (prog_addr),
    .PROG_DATA (prog_data),
    .dp        (dp_if.master),
    .PC        (pc),
    .BUSY      (busy),
    .DONE      (done),
    .OVERRUN   (overrun)
  );

  blue u_blue (
    .ins    (dp_if.INS),
    .RA     (dp_if.RA),
    .RB     (dp_if.RB),
    .RA_OUT (dp_if.ALU_RA),
    .RB_OUT (dp_if.ALU_RB)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic prog_write(input logic [3:0] addr, input logic [15:0] data);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    step();
    prog_we   = 1'b0;
    model_mem[addr] = data;
  endtask

  // Program-level reference: walk the program word by word, HALT is a no-op.
  task automatic model_run(input logic [15:0] ra0, input logic [15:0] rb0);
    logic [15:0] a, b, t, w;
    a = ra0;
    b = rb0;
    tr_ra[0] = a;
    tr_rb[0] = b;
    exp_ovr  = 1'b0;
    exp_k    = 0;
    for (int i = 0; i < 16; i++) begin
      w     = model_mem[i];
      exp_k = i + 1;
      if (!w[12]) begin
        case (w[15:13])
          3'd0: a = a + b;
          3'd1: a = a - b;
          3'd2: a = a | b;
          3'd3: a = a & b;
          3'd4: a = a ^ b;
          3'd5: a = a / 16'd2;
          3'd6: b = a;
          default: begin t = a; a = b; b = t; end
        endcase
      end
      tr_ra[i+1] = a;
      tr_rb[i+1] = b;
      if (w[12]) break;
      if (i == 15) exp_ovr = 1'b1;
    end
  endtask

  // inj_cyc>0: fire a START + PROG_WE(addr1,0xFFFF) in that BUSY cycle and a START in FIN.
  // sw_we: write sw_data to address 0 in the same cycle as START.
  task automatic run_prog(input string tag, input logic [15:0] ra0, input logic [15:0] rb0,
                          input int inj_cyc, input logic sw_we, input logic [15:0] sw_data);
    int cyc;
    int idx;
    if (sw_we) model_mem[0] = sw_data;
    model_run(ra0, rb0);
    ra_init   = ra0;
    rb_init   = rb0;
    start     = 1'b1;
    prog_we   = sw_we;
    prog_addr = 4'd0;
    prog_data = sw_data;
    step();
    cyc = 1;
    forever begin
      start   = 1'b0;
      prog_we = 1'b0;
      if (cyc == 1) chk({tag, "_ovr_clr"}, overrun, 0);
      if (cyc[0]) begin
        idx = cyc / 2;
        if (idx <= exp_k) begin
          chk({tag, "_ra_trace"}, dp_if.RA, tr_ra[idx]);
          chk({tag, "_rb_trace"}, dp_if.RB, tr_rb[idx]);
        end
      end else begin
        idx = (cyc - 2) / 2;
        if (idx < exp_k) begin
          chk({tag, "_ins"}, dp_if.INS, model_mem[idx]);
          chk({tag, "_pc"}, pc, idx);
          chk({tag, "_busy"}, busy, 1);
        end
      end
      if (inj_cyc > 0 && (cyc == inj_cyc || done)) begin
        start = 1'b1;
        if (!done) begin
          prog_we   = 1'b1;
          prog_addr = 4'd1;
          prog_data = 16'hFFFF;
        end
      end
      if (done || cyc >= 80) break;
      step();
      cyc++;
    end
    chk({tag, "_done_cyc"}, cyc, 2 * exp_k + 1);
    chk({tag, "_ra"}, dp_if.RA, tr_ra[exp_k]);
    chk({tag, "_rb"}, dp_if.RB, tr_rb[exp_k]);
    chk({tag, "_ovr"}, overrun, exp_ovr);
    chk({tag, "_pc_end"}, pc, exp_k - 1);
    step();
    start   = 1'b0;
    prog_we = 1'b0;
    chk({tag, "_done_once"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    logic [15:0] w;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;

    step();
    step();
    chk("rst_ins", dp_if.INS, 0);
    chk("rst_ra", dp_if.RA, 0);
    chk("rst_rb", dp_if.RB, 0);
    chk("rst_pc", pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovr", overrun, 0);
    rst = 1'b0;
    step();

    // ADD then HALT
    prog_write(4'd0, 16'h0000);
    prog_write(4'd1, 16'h1000);
    run_prog("t1", 16'h0003, 16'h0005, 0, 1'b0, 16'h0);
    chk("t1_ra_abs", dp_if.RA, 16'h0008);
    chk("t1_rb_abs", dp_if.RB, 16'h0005);

    // Requests while busy / in FIN are ignored
    run_prog("t4", 16'h0003, 16'h0005, 2, 1'b0, 16'h0);
    run_prog("t4_rerun", 16'h0003, 16'h0005, 0, 1'b0, 16'h0);

    // SUB, EXCH, SHR, HALT
    prog_write(4'd0, 16'h2000);
    prog_write(4'd1, 16'hE000);
    prog_write(4'd2, 16'hA000);
    prog_write(4'd3, 16'h1000);
    run_prog("t2", 16'h0010, 16'h0004, 0, 1'b0, 16'h0);
    chk("t2_ra_abs", dp_if.RA, 16'h0002);
    chk("t2_rb_abs", dp_if.RB, 16'h000C);

    // Reset in the EXEC cycle of the EXCH instruction
    ra_init = 16'h0010;
    rb_init = 16'h0004;
    start   = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("t5_ra", dp_if.RA, 0);
    chk("t5_rb", dp_if.RB, 0);
    chk("t5_ins", dp_if.INS, 0);
    chk("t5_pc", pc, 0);
    chk("t5_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_no_done", done, 0);
    end
    rst = 1'b0;
    step();
    run_prog("t5_rerun", 16'h0010, 16'h0004, 0, 1'b0, 16'h0);
    chk("t5_ra_abs", dp_if.RA, 16'h0002);

    // Overrun through all 16 words
    for (int i = 0; i < 16; i++) prog_write(4'(i), 16'h0000);
    run_prog("t3", 16'h0001, 16'h0001, 0, 1'b0, 16'h0);
    chk("t3_ra_abs", dp_if.RA, 16'h0011);
    chk("t3_ovr_abs", overrun, 1);

    // Wrap arithmetic, then same-cycle write of HALT with START
    prog_write(4'd1, 16'h1000);
    run_prog("t6a", 16'hFFFF, 16'h0002, 0, 1'b0, 16'h0);
    chk("t6a_ra_abs", dp_if.RA, 16'h0001);
    run_prog("t6b", 16'h1234, 16'h5678, 0, 1'b1, 16'h1000);
    chk("t6b_ra_abs", dp_if.RA, 16'h1234);
    chk("t6b_rb_abs", dp_if.RB, 16'h5678);

    // Random programs and operands
    for (int r = 0; r < 24; r++) begin
      for (int a = 0; a < 16; a++) begin
        w = {3'($urandom_range(0, 7)), 1'($urandom_range(0, 5) == 0), 12'h000};
        if (r % 6 == 5) w[12] = 1'b0;
        prog_write(4'(a), w);
      end
      run_prog("rnd", 16'($urandom), 16'($urandom),
               (r % 4 == 0) ? 2 * int'($urandom_range(1, 3)) : 0, 1'b0, 16'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
